// File: rtl/nvic_prio_arb.sv
// -----------------------------------------------------------------------------
// nvic_prio_arb
//
// Nested vectored interrupt controller front end for a Cortex-M0 style core.
// Captures peripheral IRQ lines (level or rising edge) into a pending
// register. It gates them with per-line enables and arbitrates by programmable
// priority against the running priority (the priority on top of a nesting
// stack). It then presents a single request to the core over a req/ack
// handshake.
//
// Handshake: irq_req is asserted with a frozen irq_num and held until the
// cycle in which the core asserts irq_ack (transfer: pending cleared, line
// made active, {num, prio} pushed), or until the request is withdrawn
// (nvic_en low, line lost enable/pending, or nesting stack full). irq_ack
// while irq_req is low is ignored. exc_return pops the nesting stack.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   nvic_en           global enable; 0 blocks/withdraws requests
//   irq_in            peripheral interrupt lines
//   iser/icer         write-1 set/clear enable (one-cycle pulses)
//   ispr/icpr         write-1 set/clear pending (one-cycle pulses)
//   ipr_we, ipr       packed priority write, line i at [i*PRIO_BITS +: PRIO_BITS]
//   irq_ack           core accepts the presented request
//   exc_return        core finished the current handler
//   irq_req, irq_num  request and line index to the core
//   enable_o          enable register
//   pending_o         pending register
//   interrupt_active  one bit per active (entered, not yet returned) line
//   nest_err          sticky: stack overflow withdraw or return on empty stack
// -----------------------------------------------------------------------------
module nvic_prio_arb #(
  parameter int NUM_IRQ    = 8,
  parameter int PRIO_BITS  = 4,
  parameter int NEST_DEPTH = 4,
  parameter int IRQ_EDGE   = 0
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           nvic_en,
  input  logic [NUM_IRQ-1:0]             irq_in,
  input  logic [NUM_IRQ-1:0]             iser,
  input  logic [NUM_IRQ-1:0]             icer,
  input  logic [NUM_IRQ-1:0]             ispr,
  input  logic [NUM_IRQ-1:0]             icpr,
  input  logic                           ipr_we,
  input  logic [NUM_IRQ*PRIO_BITS-1:0]   ipr,
  input  logic                           irq_ack,
  input  logic                           exc_return,
  output logic                           irq_req,
  output logic [4:0]                     irq_num,
  output logic [NUM_IRQ-1:0]             enable_o,
  output logic [NUM_IRQ-1:0]             pending_o,
  output logic [NUM_IRQ-1:0]             interrupt_active,
  output logic                           nest_err
);

  localparam int SPW = $clog2(NEST_DEPTH + 1);
  localparam int RPW = PRIO_BITS + 1;
  localparam logic [SPW-1:0] SP_ONE  = SPW'(1);
  localparam logic [SPW-1:0] SP_FULL = SPW'(NEST_DEPTH);

  typedef enum logic {S_IDLE, S_REQ} state_t;

  // Registered state
  state_t                 state_q;
  logic [NUM_IRQ-1:0]     enable_q;
  logic [NUM_IRQ-1:0]     pending_q;
  logic [NUM_IRQ-1:0]     active_q;
  logic [NUM_IRQ-1:0]     irq_prev_q;
  logic [PRIO_BITS-1:0]   prio_q   [NUM_IRQ];
  logic [4:0]             stk_num  [NEST_DEPTH];
  logic [PRIO_BITS-1:0]   stk_prio [NEST_DEPTH];
  logic [SPW-1:0]         sp_q;

  // Combinational terms
  logic [NUM_IRQ-1:0]     capture;
  logic [SPW-1:0]         top_idx;
  logic [4:0]             top_num;
  logic [PRIO_BITS-1:0]   top_prio;
  logic                   stack_empty;
  logic                   stack_full;
  logic [RPW-1:0]         run_prio;
  logic [NUM_IRQ-1:0]     eligible;
  logic                   win_found;
  logic [4:0]             win_idx;
  logic [PRIO_BITS-1:0]   win_prio;
  logic [NUM_IRQ-1:0]     num_oh;
  logic [NUM_IRQ-1:0]     top_oh;
  logic [PRIO_BITS-1:0]   frozen_prio;
  logic                   frozen_en;
  logic                   frozen_pend;
  logic                   pop;
  logic                   ret_err;
  logic                   full_block;
  logic                   withdraw;
  logic                   accept;
  logic [SPW-1:0]         push_idx;
  logic [SPW-1:0]         sp_d;
  logic [NUM_IRQ-1:0]     enable_d;
  logic [NUM_IRQ-1:0]     pending_d;
  logic [NUM_IRQ-1:0]     active_d;

  assign enable_o         = enable_q;
  assign pending_o        = pending_q;
  assign interrupt_active = active_q;

  // Capture: level passes the line straight through, edge mode needs the
  // registered previous sample to see a 0->1 transition.
  assign capture = (IRQ_EDGE != 0) ? (irq_in & ~irq_prev_q) : irq_in;

  assign stack_empty = (sp_q == '0);
  assign stack_full  = (sp_q == SP_FULL);
  assign top_idx     = sp_q - SP_ONE;

  // Top-of-stack read. The index loop avoids an index wider than the array.
  always_comb begin
    top_num  = '0;
    top_prio = '0;
    for (int k = 0; k < NEST_DEPTH; k++) begin
      if (SPW'(k) == top_idx) begin
        top_num  = stk_num[k];
        top_prio = stk_prio[k];
      end
    end
  end

  // With an empty stack the running priority sits one above the largest
  // programmable value so that every line can preempt.
  assign run_prio = stack_empty ? {1'b1, {PRIO_BITS{1'b0}}} : {1'b0, top_prio};

  // Eligibility and fixed-priority winner. Strict '<' on ties keeps the
  // lowest index.
  always_comb begin
    eligible  = '0;
    win_found = 1'b0;
    win_idx   = '0;
    win_prio  = '1;
    for (int i = 0; i < NUM_IRQ; i++) begin
      eligible[i] = enable_q[i] & pending_q[i] & ~active_q[i] &
                    ({1'b0, prio_q[i]} < run_prio);
      if (eligible[i] && (!win_found || (prio_q[i] < win_prio))) begin
        win_found = 1'b1;
        win_idx   = 5'(i);
        win_prio  = prio_q[i];
      end
    end
  end

  // One-hot decodes of the frozen request line and of the top-of-stack line.
  always_comb begin
    num_oh      = '0;
    top_oh      = '0;
    frozen_prio = '0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      num_oh[i] = (irq_num == 5'(i));
      top_oh[i] = (top_num == 5'(i));
      if (num_oh[i]) frozen_prio = prio_q[i];
    end
  end

  assign frozen_en   = |(enable_q & num_oh);
  assign frozen_pend = |(pending_q & num_oh);

  // A pop in the same cycle frees the slot the push is going to use.
  assign pop        = exc_return && !stack_empty;
  assign ret_err    = exc_return && stack_empty;
  assign full_block = stack_full && !pop;
  assign withdraw   = (state_q == S_REQ) &&
                      (!nvic_en || !frozen_en || !frozen_pend || full_block);
  assign accept     = (state_q == S_REQ) && !withdraw && irq_ack;
  assign push_idx   = pop ? top_idx : sp_q;

  always_comb begin
    if (accept && !pop)      sp_d = sp_q + SP_ONE;
    else if (pop && !accept) sp_d = sp_q - SP_ONE;
    else                     sp_d = sp_q;
  end

  // Register next values. Clear beats set for enable. Set (capture/ispr)
  // beats clear for pending. The ack clear beats everything on its line.
  assign enable_d  = (enable_q | iser) & ~icer;
  assign pending_d = ((pending_q & ~icpr) | capture | ispr) &
                     ~(accept ? num_oh : {NUM_IRQ{1'b0}});

  always_comb begin
    active_d = active_q;
    if (pop)    active_d = active_d & ~top_oh;
    if (accept) active_d = active_d | num_oh;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      irq_req    <= 1'b0;
      irq_num    <= '0;
      enable_q   <= '0;
      pending_q  <= '0;
      active_q   <= '0;
      irq_prev_q <= '0;
      sp_q       <= '0;
      nest_err   <= 1'b0;
      for (int i = 0; i < NUM_IRQ; i++) prio_q[i] <= '0;
      for (int k = 0; k < NEST_DEPTH; k++) begin
        stk_num[k]  <= '0;
        stk_prio[k] <= '0;
      end
    end else begin
      enable_q   <= enable_d;
      pending_q  <= pending_d;
      active_q   <= active_d;
      irq_prev_q <= irq_in;
      sp_q       <= sp_d;

      if (ipr_we) begin
        for (int i = 0; i < NUM_IRQ; i++) prio_q[i] <= ipr[i*PRIO_BITS +: PRIO_BITS];
      end

      // The stack keeps its own copy of the priority so later ipr writes
      // do not disturb the running priority of handlers already entered.
      if (accept) begin
        for (int k = 0; k < NEST_DEPTH; k++) begin
          if (SPW'(k) == push_idx) begin
            stk_num[k]  <= irq_num;
            stk_prio[k] <= frozen_prio;
          end
        end
      end

      if (ret_err || ((state_q == S_REQ) && full_block)) nest_err <= 1'b1;

      case (state_q)
        S_IDLE: begin
          if (nvic_en && win_found) begin
            state_q <= S_REQ;
            irq_req <= 1'b1;
            irq_num <= win_idx;
          end
        end
        S_REQ: begin
          if (withdraw || accept) begin
            state_q <= S_IDLE;
            irq_req <= 1'b0;
          end
        end
        default: begin
          state_q <= S_IDLE;
          irq_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nvic_prio_arb.sv
// -----------------------------------------------------------------------------
// tb_nvic_prio_arb
//
// Three instances share one set of inputs: a default level-capture
// controller (u_lvl), an edge-capture one (u_edge) and one with a two-deep
// nesting stack (u_d2). Each scenario task drives directed vectors and
// compares outputs against hand-computed values one cycle at a time.
// Inputs change and outputs are sampled 1 time unit after the rising edge.
// -----------------------------------------------------------------------------
module tb_nvic_prio_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic        nvic_en;
  logic [7:0]  irq_in, iser, icer, ispr, icpr;
  logic        ipr_we;
  logic [31:0] ipr;
  logic        irq_ack;
  logic        exc_return;

  logic       l_req, e_req, d_req;
  logic [4:0] l_num, e_num, d_num;
  logic [7:0] l_en, e_en, d_en;
  logic [7:0] l_pend, e_pend, d_pend;
  logic [7:0] l_act, e_act, d_act;
  logic       l_err, e_err, d_err;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  nvic_prio_arb #(.NUM_IRQ(8), .PRIO_BITS(4), .NEST_DEPTH(4), .IRQ_EDGE(0)) u_lvl (
    .clk(clk), .rst(rst), .nvic_en(nvic_en), .irq_in(irq_in),
    .iser(iser), .icer(icer), .ispr(ispr), .icpr(icpr),
    .ipr_we(ipr_we), .ipr(ipr), .irq_ack(irq_ack), .exc_return(exc_return),
    .irq_req(l_req), .irq_num(l_num), .enable_o(l_en), .pending_o(l_pend),
    .interrupt_active(l_act), .nest_err(l_err)
  );

  nvic_prio_arb #(.NUM_IRQ(8), .PRIO_BITS(4), .NEST_DEPTH(4), .IRQ_EDGE(1)) u_edge (
    .clk(clk), .rst(rst), .nvic_en(nvic_en), .irq_in(irq_in),
    .iser(iser), .icer(icer), .ispr(ispr), .icpr(icpr),
    .ipr_we(ipr_we), .ipr(ipr), .irq_ack(irq_ack), .exc_return(exc_return),
    .irq_req(e_req), .irq_num(e_num), .enable_o(e_en), .pending_o(e_pend),
    .interrupt_active(e_act), .nest_err(e_err)
  );

  nvic_prio_arb #(.NUM_IRQ(8), .PRIO_BITS(4), .NEST_DEPTH(2), .IRQ_EDGE(0)) u_d2 (
    .clk(clk), .rst(rst), .nvic_en(nvic_en), .irq_in(irq_in),
    .iser(iser), .icer(icer), .ispr(ispr), .icpr(icpr),
    .ipr_we(ipr_we), .ipr(ipr), .irq_ack(irq_ack), .exc_return(exc_return),
    .irq_req(d_req), .irq_num(d_num), .enable_o(d_en), .pending_o(d_pend),
    .interrupt_active(d_act), .nest_err(d_err)
  );

  // ---------------- clock / reset / driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_pulses();
    iser = '0; icer = '0; ispr = '0; icpr = '0;
    ipr_we = 1'b0; irq_ack = 1'b0; exc_return = 1'b0;
  endtask

  task automatic do_reset();
    clear_pulses();
    irq_in = '0; nvic_en = 1'b0; ipr = '0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    do_reset();
    total++; if (l_req !== 1'b0) begin bad++; $display("FAIL reset_req: got %0h want 0", l_req); end
    total++; if (l_num !== 5'd0) begin bad++; $display("FAIL reset_num: got %0h want 0", l_num); end
    total++; if (l_en !== 8'h00) begin bad++; $display("FAIL reset_en: got %0h want 0", l_en); end
    total++; if (l_pend !== 8'h00) begin bad++; $display("FAIL reset_pend: got %0h want 0", l_pend); end
    total++; if (l_act !== 8'h00) begin bad++; $display("FAIL reset_act: got %0h want 0", l_act); end
    total++; if (l_err !== 1'b0) begin bad++; $display("FAIL reset_err: got %0h want 0", l_err); end
  endtask

  task automatic test_tie();
    do_reset();
    ipr = 32'hFFFF_F00F; ipr_we = 1'b1;
    iser = 8'h06; ispr = 8'h06; nvic_en = 1'b1;
    tick();
    clear_pulses();
    total++; if (l_pend !== 8'h06) begin bad++; $display("FAIL tie_pend: got %0h want 06", l_pend); end
    total++; if (l_req !== 1'b0) begin bad++; $display("FAIL tie_req_latency: got %0h want 0", l_req); end
    tick();
    total++; if (l_req !== 1'b1) begin bad++; $display("FAIL tie_req: got %0h want 1", l_req); end
    total++; if (l_num !== 5'd1) begin bad++; $display("FAIL tie_num: got %0d want 1", l_num); end
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
    total++; if (l_pend !== 8'h04) begin bad++; $display("FAIL tie_ack_pend: got %0h want 04", l_pend); end
    total++; if (l_act !== 8'h02) begin bad++; $display("FAIL tie_ack_act: got %0h want 02", l_act); end
    total++; if (l_req !== 1'b0) begin bad++; $display("FAIL tie_ack_drop: got %0h want 0", l_req); end
    tick();
    tick();
    // Equal priority never preempts the running handler.
    total++; if (l_req !== 1'b0) begin bad++; $display("FAIL tie_no_preempt: got %0h want 0", l_req); end
  endtask

  task automatic test_set_clear();
    do_reset();
    icpr = 8'h02; ispr = 8'h02;
    tick();
    clear_pulses();
    total++; if (l_pend !== 8'h02) begin bad++; $display("FAIL sc_set_wins: got %0h want 02", l_pend); end
    icpr = 8'h02;
    tick();
    clear_pulses();
    total++; if (l_pend !== 8'h00) begin bad++; $display("FAIL sc_icpr: got %0h want 00", l_pend); end
    irq_in = 8'h02; icpr = 8'h02;
    tick();
    clear_pulses();
    irq_in = 8'h00;
    total++; if (l_pend !== 8'h02) begin bad++; $display("FAIL sc_capture_wins: got %0h want 02", l_pend); end
    iser = 8'h08;
    tick();
    clear_pulses();
    total++; if (l_en !== 8'h08) begin bad++; $display("FAIL sc_iser: got %0h want 08", l_en); end
    iser = 8'h08; icer = 8'h08;
    tick();
    clear_pulses();
    total++; if (l_en !== 8'h00) begin bad++; $display("FAIL sc_clear_wins: got %0h want 00", l_en); end
  endtask

  task automatic test_nesting();
    do_reset();
    ipr = 32'hF98F_F3FF; ipr_we = 1'b1; iser = 8'h64; nvic_en = 1'b1;
    tick();
    clear_pulses();
    ispr = 8'h20;
    tick();
    clear_pulses();
    tick();
    total++; if (l_req !== 1'b1 || l_num !== 5'd5) begin bad++; $display("FAIL nest_req5: got req=%0h num=%0d want req=1 num=5", l_req, l_num); end
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
    total++; if (l_act !== 8'h20) begin bad++; $display("FAIL nest_act5: got %0h want 20", l_act); end
    ispr = 8'h40;
    tick();
    clear_pulses();
    tick();
    tick();
    total++; if (l_req !== 1'b0) begin bad++; $display("FAIL nest_low_blocked: got %0h want 0", l_req); end
    total++; if (l_pend !== 8'h40) begin bad++; $display("FAIL nest_low_pend: got %0h want 40", l_pend); end
    ispr = 8'h04;
    tick();
    clear_pulses();
    tick();
    total++; if (l_req !== 1'b1 || l_num !== 5'd2) begin bad++; $display("FAIL nest_req2: got req=%0h num=%0d want req=1 num=2", l_req, l_num); end
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
    total++; if (l_act !== 8'h24) begin bad++; $display("FAIL nest_act24: got %0h want 24", l_act); end
    exc_return = 1'b1;
    tick();
    exc_return = 1'b0;
    total++; if (l_act !== 8'h20) begin bad++; $display("FAIL nest_pop1: got %0h want 20", l_act); end
    tick();
    total++; if (l_req !== 1'b0) begin bad++; $display("FAIL nest_still_blocked: got %0h want 0", l_req); end
    exc_return = 1'b1;
    tick();
    exc_return = 1'b0;
    total++; if (l_act !== 8'h00) begin bad++; $display("FAIL nest_pop2: got %0h want 00", l_act); end
    tick();
    total++; if (l_req !== 1'b1 || l_num !== 5'd6) begin bad++; $display("FAIL nest_req6: got req=%0h num=%0d want req=1 num=6", l_req, l_num); end
  endtask

  task automatic test_edge();
    int e_req_cycles;
    e_req_cycles = 0;
    do_reset();
    ipr = 32'h0; ipr_we = 1'b1; iser = 8'h10; nvic_en = 1'b1;
    tick();
    clear_pulses();
    irq_in = 8'h10;
    tick();
    total++; if (e_pend !== 8'h10) begin bad++; $display("FAIL edge_capture: got %0h want 10", e_pend); end
    tick();
    if (e_req) e_req_cycles++;
    total++; if (e_req !== 1'b1 || e_num !== 5'd4) begin bad++; $display("FAIL edge_req: got req=%0h num=%0d want req=1 num=4", e_req, e_num); end
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
    if (e_req) e_req_cycles++;
    tick();
    if (e_req) e_req_cycles++;
    tick();
    if (e_req) e_req_cycles++;
    irq_in = 8'h00;
    total++; if (e_pend !== 8'h00) begin bad++; $display("FAIL edge_no_repend: got %0h want 00", e_pend); end
    total++; if (l_pend !== 8'h10) begin bad++; $display("FAIL level_repend: got %0h want 10", l_pend); end
    exc_return = 1'b1;
    tick();
    exc_return = 1'b0;
    if (e_req) e_req_cycles++;
    for (int c = 0; c < 3; c++) begin
      tick();
      if (e_req) e_req_cycles++;
    end
    total++; if (e_req_cycles != 1) begin bad++; $display("FAIL edge_one_request: got %0d cycles want 1", e_req_cycles); end
    total++; if (l_req !== 1'b1 || l_num !== 5'd4) begin bad++; $display("FAIL level_second_req: got req=%0h num=%0d want req=1 num=4", l_req, l_num); end
  endtask

  task automatic test_depth();
    do_reset();
    ipr = 32'hFFFF_F246; ipr_we = 1'b1; iser = 8'h07; nvic_en = 1'b1;
    tick();
    clear_pulses();
    for (int n = 0; n < 3; n++) begin
      ispr = 8'h01 << n;
      tick();
      clear_pulses();
      tick();
      total++; if (d_req !== 1'b1 || d_num !== 5'(n)) begin bad++; $display("FAIL depth_req%0d: got req=%0h num=%0d want req=1 num=%0d", n, d_req, d_num, n); end
      irq_ack = 1'b1;
      tick();
      irq_ack = 1'b0;
    end
    total++; if (d_req !== 1'b0) begin bad++; $display("FAIL depth_withdraw: got %0h want 0", d_req); end
    total++; if (d_err !== 1'b1) begin bad++; $display("FAIL depth_err: got %0h want 1", d_err); end
    total++; if (d_act !== 8'h03) begin bad++; $display("FAIL depth_act: got %0h want 03", d_act); end
    total++; if (d_pend !== 8'h04) begin bad++; $display("FAIL depth_pend: got %0h want 04", d_pend); end
    total++; if (l_act !== 8'h07 || l_err !== 1'b0) begin bad++; $display("FAIL depth4_accept: got act=%0h err=%0h want act=07 err=0", l_act, l_err); end
    do_reset();
    exc_return = 1'b1;
    tick();
    exc_return = 1'b0;
    tick();
    total++; if (l_err !== 1'b1) begin bad++; $display("FAIL empty_return_err: got %0h want 1", l_err); end
    total++; if (l_act !== 8'h00) begin bad++; $display("FAIL empty_return_act: got %0h want 00", l_act); end
    do_reset();
    total++; if (l_err !== 1'b0) begin bad++; $display("FAIL err_reset_clear: got %0h want 0", l_err); end
  endtask

  task automatic test_ack_return();
    do_reset();
    ipr = 32'hFFFF_FF25; ipr_we = 1'b1; iser = 8'h03; nvic_en = 1'b1;
    tick();
    clear_pulses();
    ispr = 8'h01;
    tick();
    clear_pulses();
    tick();
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
    ispr = 8'h02;
    tick();
    clear_pulses();
    tick();
    total++; if (l_req !== 1'b1 || l_num !== 5'd1) begin bad++; $display("FAIL ar_req1: got req=%0h num=%0d want req=1 num=1", l_req, l_num); end
    irq_ack = 1'b1; exc_return = 1'b1;
    tick();
    clear_pulses();
    total++; if (l_act !== 8'h02) begin bad++; $display("FAIL ar_swap_act: got %0h want 02", l_act); end
    exc_return = 1'b1;
    tick();
    exc_return = 1'b0;
    total++; if (l_act !== 8'h00 || l_err !== 1'b0) begin bad++; $display("FAIL ar_pop: got act=%0h err=%0h want act=00 err=0", l_act, l_err); end
    exc_return = 1'b1;
    tick();
    exc_return = 1'b0;
    total++; if (l_err !== 1'b1) begin bad++; $display("FAIL ar_depth_one: got %0h want 1", l_err); end
  endtask

  task automatic test_en_toggle();
    logic exp_req;
    do_reset();
    iser = 8'h01; ispr = 8'h01;
    tick();
    clear_pulses();
    for (int s = 0; s < 8; s++) begin
      exp_req = (s % 2 == 0);
      nvic_en = exp_req;
      tick();
      total++; if (l_req !== exp_req) begin bad++; $display("FAIL en_toggle_req%0d: got %0h want %0h", s, l_req, exp_req); end
      total++; if (l_pend !== 8'h01) begin bad++; $display("FAIL en_toggle_pend%0d: got %0h want 01", s, l_pend); end
    end
    nvic_en = 1'b1;
    tick();
    total++; if (l_req !== 1'b1) begin bad++; $display("FAIL midreset_pre: got %0h want 1", l_req); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++; if (l_req !== 1'b0 || l_pend !== 8'h00 || l_en !== 8'h00) begin bad++; $display("FAIL midreset_clear: got req=%0h pend=%0h en=%0h want 0/00/00", l_req, l_pend, l_en); end
  endtask

  initial begin
    rst = 1'b1; nvic_en = 1'b0; irq_in = '0; ipr = '0;
    clear_pulses();
    test_reset();
    test_tie();
    test_set_clear();
    test_nesting();
    test_edge();
    test_depth();
    test_ack_return();
    test_en_toggle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/nvic_prio_arb.md
Name: nvic_prio_arb

Overview:
- Parametrised successor of the 8-input NVIC with per-line enable/pending registers, a packed priority field and an active-interrupt vector.
- Adds level or edge capture of external IRQ lines, fixed-priority arbitration with priority masking and nesting, and a req/ack handshake to the core.
- Adds an exception-return path and a nesting stack.
- Sits between the peripheral IRQ lines and the Cortex-M0 core exception-entry logic.

Parameters:
- NUM_IRQ, 8: number of interrupt lines; 2..32.
- PRIO_BITS, 4: priority bits per line; lower value means higher urgency.
- NEST_DEPTH, 4: maximum number of simultaneously active, nested interrupts.
- IRQ_EDGE, 0: 0 = level-sensitive capture, 1 = rising-edge capture, same for all lines.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- nvic_en  in  1  global enable; 0 blocks new requests.
- irq_in  in  NUM_IRQ  peripheral interrupt lines.
- iser  in  NUM_IRQ  write-1-to-set enable; each bit is a one-cycle pulse.
- icer  in  NUM_IRQ  write-1-to-clear enable.
- ispr  in  NUM_IRQ  write-1-to-set pending.
- icpr  in  NUM_IRQ  write-1-to-clear pending.
- ipr_we  in  1  priority write strobe.
- ipr  in  NUM_IRQ*PRIO_BITS  packed priorities; line i occupies [i*PRIO_BITS +: PRIO_BITS].
- irq_ack  in  1  core accepts the presented request.
- exc_return  in  1  core finished the current handler.
- irq_req  out  1  request to core.
- irq_num  out  5  index of the requested line.
- enable_o  out  NUM_IRQ  enable register.
- pending_o  out  NUM_IRQ  pending register.
- interrupt_active  out  NUM_IRQ  one bit per active line.
- nest_err  out  1  sticky error flag.

Behaviour:
- Reset (rst=1 at an edge): all registers clear.
  - enable, pending, priority and active are 0.
  - Stack pointer is 0; FSM goes to IDLE.
  - irq_req=0, irq_num=0, nest_err=0.
- Capture:
  - IRQ_EDGE=0: pending[i] sets on any edge where irq_in[i]=1.
  - IRQ_EDGE=1: pending[i] sets when irq_in[i]=1 and its registered previous value is 0. The previous-value register resets to 0.
  - Capture is independent of enable and nvic_en.
- Set/clear priority in the same cycle:
  - icer beats iser.
  - A hardware capture or ispr beats icpr.
  - irq_ack clearing pending[irq_num] beats a same-cycle capture on that line; no re-pend from the same cycle.
- Priority register: loads ipr when ipr_we=1. Priorities of already-active lines stored on the stack are unaffected.
- Eligibility: line i is eligible when all of the following hold:
  - enable[i]=1 and pending[i]=1;
  - active[i]=0;
  - prio[i] is strictly less than the running priority.
- Running priority:
  - Equals the priority saved on top-of-stack.
  - When the stack is empty it is 2^PRIO_BITS, i.e. everything preempts.
- Winner selection: the eligible line with the lowest priority value wins. On a tie, the lowest index wins.
- FSM states: IDLE and REQ.
  - IDLE -> REQ: when nvic_en=1 and a winner exists. irq_req=1 and irq_num=winner from the next edge, so the request appears one cycle after pending is visible.
  - REQ: irq_num is frozen, not re-arbitrated.
  - REQ -> IDLE on irq_ack=1:
    - pending[irq_num] clears and active[irq_num] sets.
    - Push {irq_num, prio} onto the stack.
    - irq_req drops on the same edge.
  - REQ -> IDLE, withdraw without push, when any of these happens:
    - nvic_en=0;
    - the frozen line loses enable or pending;
    - the stack is full. In this case nest_err sets.
- exc_return=1 with a non-empty stack: pop the stack and clear active[top.num].
- exc_return=1 with an empty stack: no change; nest_err sets.
- irq_ack and exc_return in the same cycle: pop first, then push into the same slot. Stack pointer is unchanged.
- irq_ack while in IDLE: ignored.
- nest_err clears only on rst.
- Reset mid-request: irq_req drops at that edge and all state is lost.

Test Plan:
1. Reset, then iser=0x06, ispr=0x06, ipr prio[1]=0, prio[2]=0, nvic_en=1:
   - irq_req=1 with irq_num=1 (tie, lowest index).
   - ack: pending_o=0x04, interrupt_active=0x02.
2. icpr=0x02 and ispr=0x02 in the same cycle -> pending[1]=1 (set wins). icer=iser=0x08 in the same cycle -> enable[3]=0.
3. Nesting with prio[5]=8 then prio[2]=3:
   - Line 5 acked; line 2 pends -> irq_req, irq_num=2.
   - Line 6 with prio 9 gets no request while 5 is active.
   - Two exc_return pulses -> interrupt_active=0.
4. IRQ_EDGE=1: hold irq_in[4]=1 for 5 cycles and ack after the first request -> exactly one request; pending[4] stays 0 afterward. With IRQ_EDGE=0 the same stimulus gives a second request.
5. NEST_DEPTH=2: three strictly-increasing-urgency interrupts -> third request withdrawn, nest_err=1. exc_return with an empty stack also gives nest_err=1.
6. nvic_en toggling each cycle, mirroring the prior bench -> irq_req withdrawn whenever nvic_en=0; pending_o is retained.
